button_debouncer: RTL
=====================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter N_BUTTONS, default 4; number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000; consecutive stable cycles required to accept a change (1 ms at 50 MHz); legal range 2..2^20.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = raw input reads 0 when pressed.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_raw  input  N_BUTTONS  board buttons; asynchronous to clk, bouncing.
REQ-007 btn_level  output  N_BUTTONS  debounced level, active-high = pressed; drives the button PIO in_port.
REQ-008 press_pulse  output  N_BUTTONS  one-cycle strobe per accepted press.
REQ-009 release_pulse  output  N_BUTTONS  one-cycle strobe per accepted release.
REQ-010 edge_clr  input  N_BUTTONS  per-bit clear for edge_latch.
REQ-011 edge_latch  output  N_BUTTONS  sticky press record.

Function
REQ-012 Each btn_raw bit SHALL pass through a two-flop synchronizer, then be normalised to active-high (inverted when ACTIVE_LOW=1).
REQ-013 Each channel SHALL own a counter of width $clog2(DEBOUNCE_CYCLES) and a two-state FSM: STABLE, COUNTING.
REQ-014 STABLE -> COUNTING when normalised sync value differs from btn_level; counter loads 1.
REQ-015 COUNTING: counter increments each cycle the mismatch persists; returns to STABLE with counter cleared the first cycle the mismatch disappears (bounce).
REQ-016 COUNTING: on the edge where counter = DEBOUNCE_CYCLES-1 and mismatch persists, btn_level bit SHALL toggle, counter clears, FSM -> STABLE.
REQ-017 Latency raw change -> btn_level change SHALL be exactly 2 + DEBOUNCE_CYCLES clk cycles for a clean step.
REQ-018 press_pulse bit SHALL be high exactly in the first cycle btn_level bit reads 1; release_pulse in the first cycle it reads 0; never both at once.
REQ-019 Counter SHALL never wrap; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-020 Channels SHALL be fully independent; simultaneous events on several bits behave as if isolated.
REQ-021 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-022 Under reset_n=0: synchronizer flops at released level (1 if ACTIVE_LOW else 0), btn_level 0, press_pulse 0, release_pulse 0, edge_latch 0, counters 0, FSM STABLE.
REQ-023 Reset asserted mid-count SHALL discard the count; after release a held button re-qualifies with full 2 + DEBOUNCE_CYCLES latency.
REQ-024 A button held through reset deassertion SHALL produce one press_pulse once qualified.

Configuration
REQ-025 Macro BUTTON_DEBOUNCER_EDGE_LATCH_EN SHALL select the sticky edge latch.
REQ-026 Defined: edge_latch bit sets on press_pulse, clears on edge_clr bit in the following cycle; simultaneous set and clear -> set wins.
REQ-027 Undefined: edge_latch tied to 0, edge_clr ignored; port list unchanged.

Verification (bench uses N_BUTTONS=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1)
REQ-028 btn_raw 4'hF -> 4'hE held -> btn_level 4'h1 exactly 10 cycles later, press_pulse 4'h1 for one cycle.
REQ-029 btn_raw[0] bounces 0/1 at 3-cycle intervals for 30 cycles, then held 0 -> no pulse during bounce, btn_level[0]=1 10 cycles after final edge.
REQ-030 btn_raw 4'hF -> 4'h0 same cycle, held 20 cycles, then 4'hF -> press_pulse 4'hF in one cycle, later release_pulse 4'hF in one cycle.
REQ-031 reset_n pulsed low at count 5 of a press -> all outputs 0 during reset; btn_level rises 10 cycles after reset_n release.
REQ-032 With EDGE_LATCH_EN: press bit 2, edge_latch=4'h4; edge_clr=4'h4 coincident with new press_pulse -> stays 4'h4; lone edge_clr -> 4'h0. Without macro: edge_latch stays 4'h0 throughout.

Source files
------------

// File: rtl/button_debouncer.sv
// Per-channel two-flop synchronizer and debouncer with registered level, press and release strobes.
// Optional sticky press record: define BUTTON_DEBOUNCER_EDGE_LATCH_EN; otherwise edge_latch reads 0.
//
// state       | meaning
// ST_STABLE   | synchronized input agrees with btn_level, counter idle at 0
// ST_COUNTING | mismatch seen, counter tracks consecutive mismatch cycles
`timescale 1ns/1ps
module button_debouncer #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    input  logic [N_BUTTONS-1:0] edge_clr,
    output logic [N_BUTTONS-1:0] edge_latch
);
    localparam int                   CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BUTTONS-1:0] SYNC_IDLE = {N_BUTTONS{ACTIVE_LOW}};

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    logic [N_BUTTONS-1:0] sync_1;
    logic [N_BUTTONS-1:0] sync_2;
    logic [N_BUTTONS-1:0] btn_norm;
    logic [N_BUTTONS-1:0] mismatch;
    logic [N_BUTTONS-1:0] toggle;

    // Synchronizer resets to the released level so a held button qualifies as a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= SYNC_IDLE;
            sync_2 <= SYNC_IDLE;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    assign btn_norm = ACTIVE_LOW ? ~sync_2 : sync_2;
    assign mismatch = btn_norm ^ btn_level;

    for (genvar ch = 0; ch < N_BUTTONS; ch++) begin : g_chan
        state_t        state;
        state_t        state_nx;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nx;
        logic          toggle_ch;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= ST_STABLE;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        always_comb begin
            state_nx  = state;
            cnt_nx    = cnt;
            toggle_ch = 1'b0;
            case (state)
                ST_STABLE: begin
                    if (mismatch[ch]) begin
                        state_nx = ST_COUNTING;
                        cnt_nx   = CW'(1);
                    end
                end
                ST_COUNTING: begin
                    if (!mismatch[ch]) begin
                        state_nx = ST_STABLE;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx  = ST_STABLE;
                        cnt_nx    = '0;
                        toggle_ch = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_STABLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        assign toggle[ch] = toggle_ch;
    end

    // Strobes are registered alongside the level so they coincide with its first new cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            btn_level     <= btn_level ^ toggle;
            press_pulse   <= toggle & ~btn_level;
            release_pulse <= toggle & btn_level;
        end
    end

`ifdef BUTTON_DEBOUNCER_EDGE_LATCH_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_latch <= '0;
        end else begin
            edge_latch <= (edge_latch & ~edge_clr) | press_pulse;
        end
    end
`else
    logic unused_edge_clr;
    assign unused_edge_clr = ^edge_clr;
    assign edge_latch      = '0;
`endif

endmodule
